adc_fifo_read_sequencer: RTL and testbench

Sequences word reads from the ADC sample FIFO into bursts requested by the USB register layer. It sits between the ADC FIFO register block and the FIFO read port, and owns `fifo_rd_en`. It paces reads in slow (every other cycle) or fast (back-to-back) mode, stalls on FIFO empty, counts underflow episodes and streaming segments, and reports burst completion.

---
 rtl/adc_fifo_read_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_adc_fifo_read_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fifo_read_sequencer.sv
// adc_fifo_read_sequencer: paces ADC sample FIFO reads into bursts
// requested by the USB register layer and owns the FIFO read strobe.
//
// Ports:
//   clk_usb, reset            : clock, synchronous active-high reset
//   start, burst_len,
//   fast_mode, abort          : burst request / termination
//   stream_segment_threshold  : words per segment (0 = no tracking)
//   no_underflow_errors       : mask underflow counting in slow mode
//   clear_stats               : clear segment and underflow statistics
//   fifo_empty / fifo_rd_en   : FIFO read port
//   word_valid                : FIFO data valid (rd_en delayed 1 cycle)
//   busy, done, segment_done  : status and pulses
//   segment_count,
//   underflow_count,
//   underflow_flag            : statistics
//   debug_read_count          : total reads (ADCFIFO_SEQ_DEBUG_EN), else 0
//
// Optional feature macro: ADCFIFO_SEQ_DEBUG_EN

module adc_fifo_read_sequencer #(
    parameter int pLEN_W = 16
) (
    input  logic              clk_usb,
    input  logic              reset,
    input  logic              start,
    input  logic [pLEN_W-1:0] burst_len,
    input  logic              fast_mode,
    input  logic              abort,
    input  logic [16:0]       stream_segment_threshold,
    input  logic              no_underflow_errors,
    input  logic              clear_stats,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              word_valid,
    output logic              busy,
    output logic              done,
    output logic              segment_done,
    output logic [15:0]       segment_count,
    output logic [7:0]        underflow_count,
    output logic              underflow_flag,
    output logic [31:0]       debug_read_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        STALL,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [pLEN_W-1:0] remaining_q, remaining_d;
    logic              fast_q, fast_d;
    logic              word_valid_q;
    logic [16:0]       seg_cnt_q, seg_cnt_d;
    logic              segment_done_q, segment_done_d;
    logic [15:0]       segment_count_q, segment_count_d;
    logic [7:0]        underflow_count_q, underflow_count_d;
    logic              underflow_flag_q, underflow_flag_d;
    logic              rd_en;
    logic              count_uf;
    logic [16:0]       seg_inc;

    // Burst sequencing
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fast_d      = fast_q;
        rd_en       = 1'b0;
        count_uf    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        remaining_d = burst_len;
                        fast_d      = fast_mode;
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d = DONE;
                end else if (fifo_empty) begin
                    state_d = STALL;
                    // Slow-mode underflows may be declared benign.
                    count_uf = fast_q || !no_underflow_errors;
                end else begin
                    rd_en       = 1'b1;
                    remaining_d = remaining_q - pLEN_W'(1);
                    if (remaining_q == pLEN_W'(1)) begin
                        state_d = DONE;
                    end else if (fast_q) begin
                        state_d = READ;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = abort ? DONE : READ;
            end
            STALL: begin
                if (abort) begin
                    state_d = DONE;
                end else if (!fifo_empty) begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Segment and underflow statistics
    assign seg_inc = seg_cnt_q + 17'd1;

    always_comb begin
        seg_cnt_d         = seg_cnt_q;
        segment_done_d    = 1'b0;
        segment_count_d   = segment_count_q;
        underflow_count_d = underflow_count_q;
        underflow_flag_d  = underflow_flag_q;
        if (clear_stats) begin
            seg_cnt_d         = '0;
            segment_count_d   = '0;
            underflow_count_d = '0;
            underflow_flag_d  = 1'b0;
        end else begin
            if (rd_en) begin
                // >= also recovers if the threshold is lowered mid-segment.
                if (stream_segment_threshold != '0 &&
                    seg_inc >= stream_segment_threshold) begin
                    seg_cnt_d       = '0;
                    segment_done_d  = 1'b1;
                    segment_count_d = segment_count_q + 16'd1;
                end else begin
                    seg_cnt_d = seg_inc;
                end
            end
            if (count_uf) begin
                underflow_flag_d = 1'b1;
                if (underflow_count_q != 8'hFF) begin
                    underflow_count_d = underflow_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_q           <= IDLE;
            remaining_q       <= '0;
            fast_q            <= 1'b0;
            word_valid_q      <= 1'b0;
            seg_cnt_q         <= '0;
            segment_done_q    <= 1'b0;
            segment_count_q   <= '0;
            underflow_count_q <= '0;
            underflow_flag_q  <= 1'b0;
        end else begin
            state_q           <= state_d;
            remaining_q       <= remaining_d;
            fast_q            <= fast_d;
            word_valid_q      <= rd_en;
            seg_cnt_q         <= seg_cnt_d;
            segment_done_q    <= segment_done_d;
            segment_count_q   <= segment_count_d;
            underflow_count_q <= underflow_count_d;
            underflow_flag_q  <= underflow_flag_d;
        end
    end

`ifdef ADCFIFO_SEQ_DEBUG_EN
    logic [31:0] dbg_cnt_q, dbg_cnt_d;

    always_comb begin
        dbg_cnt_d = dbg_cnt_q;
        if (rd_en) begin
            dbg_cnt_d = dbg_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            dbg_cnt_q <= '0;
        end else begin
            dbg_cnt_q <= dbg_cnt_d;
        end
    end

    assign debug_read_count = dbg_cnt_q;
`else
    assign debug_read_count = '0;
`endif

    assign fifo_rd_en      = rd_en;
    assign word_valid      = word_valid_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign segment_done    = segment_done_q;
    assign segment_count   = segment_count_q;
    assign underflow_count = underflow_count_q;
    assign underflow_flag  = underflow_flag_q;

endmodule

// File: tb/tb_adc_fifo_read_sequencer.sv
// tb_adc_fifo_read_sequencer: directed vectors for the ADC FIFO read
// sequencer with hand-computed per-cycle expectations.

module tb_adc_fifo_read_sequencer;

    logic        clk_usb = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] burst_len;
    logic        fast_mode;
    logic        abort;
    logic [16:0] stream_segment_threshold;
    logic        no_underflow_errors;
    logic        clear_stats;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        word_valid;
    logic        busy;
    logic        done;
    logic        segment_done;
    logic [15:0] segment_count;
    logic [7:0]  underflow_count;
    logic        underflow_flag;
    logic [31:0] debug_read_count;

    adc_fifo_read_sequencer #(.pLEN_W(16)) dut (
        .clk_usb                  (clk_usb),
        .reset                    (reset),
        .start                    (start),
        .burst_len                (burst_len),
        .fast_mode                (fast_mode),
        .abort                    (abort),
        .stream_segment_threshold (stream_segment_threshold),
        .no_underflow_errors      (no_underflow_errors),
        .clear_stats              (clear_stats),
        .fifo_empty               (fifo_empty),
        .fifo_rd_en               (fifo_rd_en),
        .word_valid               (word_valid),
        .busy                     (busy),
        .done                     (done),
        .segment_done             (segment_done),
        .segment_count            (segment_count),
        .underflow_count          (underflow_count),
        .underflow_flag           (underflow_flag),
        .debug_read_count         (debug_read_count)
    );

    always #5 clk_usb = ~clk_usb;

    int vectors     = 0;
    int miscompares = 0;
    int n_rd        = 0;
    int bad_rd      = 0;
    int abort_at    = -1;
    int restart_at  = -1;

    logic [63:0] emp_v;
    logic [63:0] rd_h, dn_h, bz_h, wv_h, sd_h;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rec(input int c);
        rd_h[c] = fifo_rd_en;
        dn_h[c] = done;
        bz_h[c] = busy;
        wv_h[c] = word_valid;
        sd_h[c] = segment_done;
        if (fifo_rd_en) begin
            n_rd++;
            if (fifo_empty) bad_rd++;
        end
    endtask

    // Issue start in the current cycle (cycle 0), then run ncyc cycles.
    task automatic run(input int len, input bit fast, input int ncyc);
        rd_h = '0; dn_h = '0; bz_h = '0; wv_h = '0; sd_h = '0;
        burst_len  = len[15:0];
        fast_mode  = fast;
        start      = 1'b1;
        abort      = 1'b0;
        fifo_empty = emp_v[0];
        #1 rec(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk_usb);
            start = (c == restart_at);
            if (c == restart_at) burst_len = 16'd9;
            fifo_empty = emp_v[c];
            abort      = (c == abort_at);
            #1 rec(c);
        end
        start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_usb);
        clear_stats = 1'b1;
        @(negedge clk_usb);
        clear_stats = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; burst_len = '0; fast_mode = 1'b0;
        abort = 1'b0; stream_segment_threshold = '0;
        no_underflow_errors = 1'b0; clear_stats = 1'b0; fifo_empty = 1'b0;
        emp_v = '0;
        repeat (3) @(negedge clk_usb);
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_wv", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_segdone", segment_done, 0);
        check("rst_segcnt", segment_count, 0);
        check("rst_uf", {underflow_flag, underflow_count}, 0);
        check("rst_dbg", debug_read_count, 0);
        @(negedge clk_usb);
        reset = 1'b0;

        // Fast burst of 8, FIFO never empty
        run(8, 1'b1, 12);
        check("fast8_rd", rd_h, 64'h1FE);
        check("fast8_done", dn_h, 64'h200);
        check("fast8_busy", bz_h, 64'h3FE);
        check("fast8_wv", wv_h, 64'h3FC);
        check("fast8_uf", underflow_count, 0);

        // Slow burst of 4, FIFO empty cycles 4..8
        pulse_clear();
        emp_v = 64'h1F0;
        run(4, 1'b0, 15);
        check("slow4_rd", rd_h, 64'h140A);
        check("slow4_done", dn_h, 64'h2000);
        check("slow4_ufcnt", underflow_count, 1);
        check("slow4_ufflag", underflow_flag, 1);
        pulse_clear();
        check("clr_ufcnt", underflow_count, 0);
        check("clr_ufflag", underflow_flag, 0);
        no_underflow_errors = 1'b1;
        run(4, 1'b0, 15);
        check("slow4m_rd", rd_h, 64'h140A);
        check("slow4m_ufcnt", underflow_count, 0);
        check("slow4m_ufflag", underflow_flag, 0);
        no_underflow_errors = 1'b0;
        emp_v = '0;

        // Segments of 3 over two fast bursts of 5
        stream_segment_threshold = 17'd3;
        pulse_clear();
        check("seg_clr", segment_count, 0);
        run(5, 1'b1, 7);
        check("segA_pulse", sd_h, 64'h10);
        check("segA_cnt", segment_count, 1);
        run(5, 1'b1, 7);
        check("segB_pulse", sd_h, 64'h24);
        check("segB_cnt", segment_count, 3);
        stream_segment_threshold = '0;

        // Abort after the 2nd read of a 10-word burst
        abort_at = 3;
        run(10, 1'b1, 6);
        abort_at = -1;
        check("abort_rd", rd_h, 64'h6);
        check("abort_done", dn_h, 64'h10);
        check("abort_busy", bz_h, 64'h1E);

        // Zero-length burst
        run(0, 1'b1, 3);
        check("zero_rd", rd_h, 64'h0);
        check("zero_done", dn_h, 64'h2);
        check("zero_busy", bz_h, 64'h2);

        // Start while busy is ignored
        restart_at = 2;
        run(4, 1'b1, 7);
        restart_at = -1;
        check("rstart_rd", rd_h, 64'h1E);
        check("rstart_done", dn_h, 64'h20);

        // 300 underflow episodes: saturation at 255
        @(negedge clk_usb);
        burst_len = 16'd5; fast_mode = 1'b1; start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk_usb);
            start = 1'b0;
            fifo_empty = (c % 2 == 1);
            #1;
            if (fifo_rd_en) begin
                n_rd++;
                if (fifo_empty) bad_rd++;
            end
            if (c == 508) check("uf_254", underflow_count, 254);
            if (c == 510) check("uf_255", underflow_count, 255);
        end
        @(negedge clk_usb);
        fifo_empty = 1'b0; abort = 1'b1;
        #1;
        check("abort_force_rd", fifo_rd_en, 0);
        @(negedge clk_usb);
        abort = 1'b0;
        #1;
        check("uf_done", done, 1);
        check("uf_sat", underflow_count, 255);
        check("uf_flag", underflow_flag, 1);
        pulse_clear();
        check("uf_clr", underflow_count, 0);
        check("uf_clrflag", underflow_flag, 0);

        check("rd_total", n_rd, 32);
        check("rd_while_empty", bad_rd, 0);
`ifdef ADCFIFO_SEQ_DEBUG_EN
        check("dbg_count", debug_read_count, 32);
`else
        check("dbg_tied", debug_read_count, 0);
`endif

        // Reset mid-burst discards the burst without done
        @(negedge clk_usb);
        burst_len = 16'd10; fast_mode = 1'b1; start = 1'b1;
        @(negedge clk_usb);
        start = 1'b0;
        #1 check("mid_rd", fifo_rd_en, 1);
        @(negedge clk_usb);
        reset = 1'b1;
        @(negedge clk_usb);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd", fifo_rd_en, 0);
        check("mid_rst_dbg", debug_read_count, 0);
        reset = 1'b0;
        @(negedge clk_usb);
        #1;
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
